// File: rtl/gcdlcm_coproc_ctrl_if.sv
`default_nettype none
//============================================================================
// Module      : gcdlcm_coproc_ctrl_if
// Description : Core <-> GCD/LCM sequencer handshake bundle.
//               master : core side (drives start/op_lcm/a/b)
//               slave  : sequencer side (drives stall/done/result/overflow)
//   start     core -> seq   gcd/lcm instruction present in decode
//   op_lcm    core -> seq   0 = gcd, 1 = lcm
//   a, b      core -> seq   rs1 / rs2 operand values (unsigned)
//   stall     seq  -> core  freeze fetch/decode/PC
//   done      seq  -> core  one-cycle result-valid pulse
//   result    seq  -> core  gcd, or low WIDTH bits of lcm
//   overflow  seq  -> core  lcm does not fit in WIDTH bits
// Revision    : 1.0 - initial release
//============================================================================
interface gcdlcm_coproc_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op_lcm;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             overflow;

    modport master (
        output start, op_lcm, a, b,
        input  stall, done, result, overflow
    );

    modport slave (
        input  start, op_lcm, a, b,
        output stall, done, result, overflow
    );
endinterface
`default_nettype wire

// File: rtl/gcdlcm_coproc_ctrl.sv
`default_nettype none
//============================================================================
// Module      : gcdlcm_coproc_ctrl
// Description : Multi-cycle sequencer for the custom GCD/LCM instructions.
//               Binary (Stein) GCD, then for LCM a restoring divide a/g
//               followed by a shift-add multiply by b.
// Ports       : clk    - clock, rising edge
//               reset  - synchronous active-high reset
//               bus    - gcdlcm_coproc_ctrl_if.slave (start/op_lcm/a/b in,
//                        stall/done/result/overflow out)
// Revision    : 1.0 - initial release
//============================================================================
module gcdlcm_coproc_ctrl #(
    parameter int WIDTH = 32
) (
    input  wire logic              clk,
    input  wire logic              reset,
    gcdlcm_coproc_ctrl_if.slave    bus
);
    localparam int              CW         = $clog2(WIDTH);
    localparam logic [CW-1:0]   C_CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_GCD  = 3'd1,
        S_DIV  = 3'd2,
        S_MUL  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    // Latched instruction
    logic                 r_op;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    // GCD working set
    logic [WIDTH-1:0]     r_x;
    logic [WIDTH-1:0]     r_y;
    logic [CW-1:0]        r_k;
    logic [WIDTH-1:0]     r_g;
    // Divide / multiply working set (r_q is quotient, then multiplier)
    logic [WIDTH-1:0]     r_q;
    logic [WIDTH-1:0]     r_rem;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_p;
    logic [2*WIDTH-1:0]   r_mcand;
    // Result held for the DONE cycle
    logic [WIDTH-1:0]     r_res;
    logic                 r_ovf;

    logic                 w_zero_op;
    logic                 w_gcd_eq;
    logic                 w_cnt_last;
    logic [WIDTH:0]       w_div_trial;
    logic                 w_div_ge;
    logic [WIDTH-1:0]     w_div_rem;
    logic [WIDTH-1:0]     w_div_q;
    logic [2*WIDTH-1:0]   w_mul_p;
    logic                 w_stall;
    logic                 w_done;
    logic [WIDTH-1:0]     w_result;
    logic                 w_ovf;

    assign w_zero_op  = (bus.a == '0) || (bus.b == '0);
    assign w_gcd_eq   = (r_x == r_y);
    assign w_cnt_last = (r_cnt == C_CNT_LAST);

    // Restoring divide step: shift next dividend bit into the remainder.
    // When the trial value reaches g the difference is below 2**WIDTH, so
    // modulo-2**WIDTH subtraction on the low bits is exact.
    assign w_div_trial = {r_rem, r_q[WIDTH-1]};
    assign w_div_ge    = (w_div_trial >= {1'b0, r_g});
    assign w_div_rem   = w_div_ge ? (w_div_trial[WIDTH-1:0] - r_g)
                                  : w_div_trial[WIDTH-1:0];
    assign w_div_q     = {r_q[WIDTH-2:0], w_div_ge};

    // Shift-add multiply step: multiplier LSB gates the shifted multiplicand.
    assign w_mul_p     = r_q[0] ? (r_p + r_mcand) : r_p;

    //------------------------------------------------------------------
    // State register
    //------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    //------------------------------------------------------------------
    // Next state and outputs
    //------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        w_done       = 1'b0;
        w_result     = '0;
        w_ovf        = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Stall must rise in the same cycle the instruction decodes
                w_stall = bus.start;
                if (bus.start) begin
                    w_state_next = w_zero_op ? S_DONE : S_GCD;
                end
            end
            S_GCD: begin
                w_stall = 1'b1;
                if (w_gcd_eq) begin
                    w_state_next = r_op ? S_DIV : S_DONE;
                end
            end
            S_DIV: begin
                w_stall = 1'b1;
                if (w_cnt_last) begin
                    w_state_next = S_MUL;
                end
            end
            S_MUL: begin
                w_stall = 1'b1;
                if (w_cnt_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                // start is still the retiring instruction here; ignore it
                w_done       = 1'b1;
                w_result     = r_res;
                w_ovf        = r_ovf;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    //------------------------------------------------------------------
    // Datapath
    //------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op    <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_k     <= '0;
            r_g     <= '0;
            r_q     <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_p     <= '0;
            r_mcand <= '0;
            r_res   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_op  <= bus.op_lcm;
                        r_a   <= bus.a;
                        r_b   <= bus.b;
                        r_x   <= bus.a;
                        r_y   <= bus.b;
                        r_k   <= '0;
                        r_ovf <= 1'b0;
                        // Zero-operand fast path: gcd = a|b, lcm = 0
                        if (w_zero_op && !bus.op_lcm) begin
                            r_res <= bus.a | bus.b;
                        end else begin
                            r_res <= '0;
                        end
                    end
                end
                S_GCD: begin
                    if (w_gcd_eq) begin
                        r_g   <= r_x << r_k;
                        r_res <= r_x << r_k;
                        r_q   <= r_a;
                        r_rem <= '0;
                        r_cnt <= '0;
                    end else if (!r_x[0] && !r_y[0]) begin
                        r_x <= r_x >> 1;
                        r_y <= r_y >> 1;
                        r_k <= r_k + CW'(1);
                    end else if (!r_x[0]) begin
                        r_x <= r_x >> 1;
                    end else if (!r_y[0]) begin
                        r_y <= r_y >> 1;
                    end else if (r_x > r_y) begin
                        r_x <= (r_x - r_y) >> 1;
                    end else begin
                        r_y <= (r_y - r_x) >> 1;
                    end
                end
                S_DIV: begin
                    r_rem <= w_div_rem;
                    r_q   <= w_div_q;
                    if (w_cnt_last) begin
                        r_cnt   <= '0;
                        r_p     <= '0;
                        r_mcand <= {{WIDTH{1'b0}}, r_b};
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_MUL: begin
                    r_p     <= w_mul_p;
                    r_mcand <= r_mcand << 1;
                    r_q     <= r_q >> 1;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_cnt_last) begin
                        r_res <= w_mul_p[WIDTH-1:0];
                        r_ovf <= |w_mul_p[2*WIDTH-1:WIDTH];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.stall    = w_stall;
    assign bus.done     = w_done;
    assign bus.result   = w_result;
    assign bus.overflow = w_ovf;

endmodule
`default_nettype wire
